// File: rtl/paralelo_serial_tx.sv
// ----------------------------------------------------------------------------
// paralelo_serial_tx : byte-to-bit serializer, MSB first, one word per 8 clk_8f
// Rev 1.0 | macro IDLE_COMMA_EN selects idle word 8'hBC (else 8'h00)
// ----------------------------------------------------------------------------
`default_nettype none

module paralelo_serial_tx (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       active_out,
   output logic       frame_start
);

`ifdef IDLE_COMMA_EN
   localparam logic [7:0] c_IDLE_WORD = 8'hBC;
`else
   localparam logic [7:0] c_IDLE_WORD = 8'h00;
`endif

   logic [2:0] slot_q, slot_d;
   logic [7:0] shift_q, shift_d;
   logic       active_q, active_d;
   logic       frame_q, frame_d;
   logic [7:0] load_word;

   assign ready_out = reset && (slot_q == 3'd7);

   always_comb begin
      slot_d    = slot_q + 3'd1;
      shift_d   = {shift_q[6:0], 1'b0};
      active_d  = active_q;
      frame_d   = 1'b0;
      load_word = valid_in ? data_in : c_IDLE_WORD;
      // The MSB of the shift register is the serial output flop itself
      if (ready_out) begin
         shift_d  = load_word;
         active_d = valid_in;
         frame_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         slot_q   <= 3'd7;
         shift_q  <= 8'h00;
         active_q <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         shift_q  <= shift_d;
         active_q <= active_d;
         frame_q  <= frame_d;
      end
   end

   assign data_out    = shift_q[7];
   assign active_out  = active_q;
   assign frame_start = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_paralelo_serial_tx.sv
// ----------------------------------------------------------------------------
// tb_paralelo_serial_tx : scoreboard bench for paralelo_serial_tx
// Rev 1.0 | honours IDLE_COMMA_EN the same way as the design
// ----------------------------------------------------------------------------
`default_nettype none

module tb_paralelo_serial_tx;

`ifdef IDLE_COMMA_EN
   localparam logic [7:0] c_IDLE = 8'hBC;
`else
   localparam logic [7:0] c_IDLE = 8'h00;
`endif

   typedef struct packed {
      logic d;
      logic a;
      logic f;
   } exp_t;

   logic       clk_8f = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out, data_out, active_out, frame_start;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cnt = 0;           // cycles since reset release, modulo 8
   logic prev_rst = 1'b0;
   logic seen = 1'b0;

   paralelo_serial_tx dut (
      .clk_8f     (clk_8f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .data_out   (data_out),
      .active_out (active_out),
      .frame_start(frame_start)
   );

   always #5 clk_8f = ~clk_8f;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: every 8th released cycle takes one word, emitted MSB first
   always @(posedge clk_8f) begin
      logic [7:0] w;
      seen     <= 1'b1;
      prev_rst <= reset;
      if (!reset) begin
         cnt = 0;
      end else begin
         if (cnt == 0) begin
            w = valid_in ? data_in : c_IDLE;
            for (int i = 0; i < 8; i++)
               exp_q.push_back('{d: w[7-i], a: valid_in, f: (i == 0)});
         end
         cnt = (cnt + 1) % 8;
      end
   end

   always @(negedge clk_8f) begin
      exp_t e;
      if (seen) begin
         if (!prev_rst) begin
            exp_q.delete();
            chk("reset data_out", {7'd0, data_out}, 8'd0);
            chk("reset active_out", {7'd0, active_out}, 8'd0);
            chk("reset frame_start", {7'd0, frame_start}, 8'd0);
         end else if (exp_q.size() == 0) begin
            chk("scoreboard empty", 8'd1, 8'd0);
         end else begin
            e = exp_q.pop_front();
            chk("data_out", {7'd0, data_out}, {7'd0, e.d});
            chk("active_out", {7'd0, active_out}, {7'd0, e.a});
            chk("frame_start", {7'd0, frame_start}, {7'd0, e.f});
         end
      end
   end

   // junk=1: outside the load slot drive random values that must be ignored
   task automatic drive(input logic r, input logic v, input logic [7:0] d, input bit junk);
      @(negedge clk_8f);
      reset = r;
      if (junk && cnt != 0) begin
         valid_in = 1'($urandom);
         data_in  = 8'($urandom);
      end else begin
         valid_in = v;
         data_in  = d;
      end
      #1 chk("ready_out", {7'd0, ready_out}, {7'd0, (r && cnt == 0)});
   endtask

   task automatic word(input logic v, input logic [7:0] d);
      for (int i = 0; i < 8; i++) drive(1'b1, v, d, 1'b1);
   endtask

   initial begin
      logic [7:0] d;
      logic       v;
      repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0);
      repeat (3) word(1'b0, 8'($urandom));
      repeat (3) word(1'b1, 8'hA5);
      word(1'b1, 8'hFF);
      word(1'b1, 8'h00);
      word(1'b0, 8'h77);
      word(1'b0, 8'h00);
      word(1'b1, 8'hBC);
      word(1'b0, 8'hBC);
      // reset lands on the edge that would present bit 3 of 8'h3C
      repeat (4) drive(1'b1, 1'b1, 8'h3C, 1'b1);
      repeat (3) drive(1'b0, 1'b1, 8'hFF, 1'b0);
      word(1'b1, 8'h5A);
      word(1'b0, 8'h00);
      repeat (40) begin
         v = 1'($urandom);
         d = ($urandom_range(0, 3) == 0) ? 8'hBC : 8'($urandom);
         word(v, d);
      end
      repeat (2) @(negedge clk_8f);
      #2 $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
